// File: rtl/seg_display_ctrl.sv
// Multiplexed common-anode 7-segment controller with hex decode, masks,
// blink, anti-ghost guard blanking and register read-back.
module seg_display_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int SCAN_DIV    = 20000,
    parameter int GUARD       = 100,
    parameter int BLINK_SCANS = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  we,
    input  logic [1:0]            addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic [7:0]            led_seg,
    output logic [NUM_DIGITS-1:0] dig_sel
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
    localparam logic [DW-1:0] DMAX  = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] GLIM  = DW'(GUARD);
    localparam logic [FW-1:0] FMAX  = FW'(BLINK_SCANS - 1);
    localparam logic [2:0]    IMAX  = 3'(NUM_DIGITS - 1);
    localparam logic [7:0]    VALID = 8'((1 << NUM_DIGITS) - 1);

    logic [4*NUM_DIGITS-1:0] data_q;
    logic [7:0]              en_mask;
    logic [7:0]              dp_mask;
    logic                    disp_en;
    logic                    blink_en;

    logic [DW-1:0] div_cnt;
    logic [2:0]    idx;
    logic [FW-1:0] frame_cnt;
    logic          blink_ph;

    logic          frame_wrap;
    logic          blank;
    logic [31:0]   data32;
    logic [3:0]    nibble;
    logic [7:0]    sel8;
    logic          unused_bits;

    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        case (v)
            4'h0: hex_decode = 7'h40;
            4'h1: hex_decode = 7'h79;
            4'h2: hex_decode = 7'h24;
            4'h3: hex_decode = 7'h30;
            4'h4: hex_decode = 7'h19;
            4'h5: hex_decode = 7'h12;
            4'h6: hex_decode = 7'h02;
            4'h7: hex_decode = 7'h78;
            4'h8: hex_decode = 7'h00;
            4'h9: hex_decode = 7'h10;
            4'hA: hex_decode = 7'h08;
            4'hB: hex_decode = 7'h03;
            4'hC: hex_decode = 7'h46;
            4'hD: hex_decode = 7'h21;
            4'hE: hex_decode = 7'h06;
            default: hex_decode = 7'h0E;
        endcase
    endfunction

    assign unused_bits = ^wdata;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q   <= '0;
            en_mask  <= VALID;
            dp_mask  <= '0;
            disp_en  <= 1'b1;
            blink_en <= 1'b0;
        end else if (we) begin
            if (addr == 2'd0) begin
                data_q <= wdata[4*NUM_DIGITS-1:0];
            end else if (addr == 2'd1) begin
                en_mask  <= wdata[7:0] & VALID;
                dp_mask  <= wdata[15:8] & VALID;
                disp_en  <= wdata[16];
                blink_en <= wdata[17];
            end
        end
    end

    assign frame_wrap = (div_cnt == DMAX) && (idx == IMAX);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt   <= '0;
            idx       <= '0;
            frame_cnt <= '0;
            blink_ph  <= 1'b0;
        end else begin
            if (div_cnt == DMAX) begin
                div_cnt <= '0;
                idx     <= (idx == IMAX) ? 3'd0 : idx + 3'd1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            // Blink phase only runs while blink is enabled
            if (!blink_en) begin
                frame_cnt <= '0;
                blink_ph  <= 1'b0;
            end else if (frame_wrap) begin
                if (frame_cnt == FMAX) begin
                    frame_cnt <= '0;
                    blink_ph  <= ~blink_ph;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    assign data32 = 32'(data_q);
    assign nibble = data32[{idx, 2'b00} +: 4];
    assign sel8   = ~(8'b1 << idx);
    assign blank  = (div_cnt < GLIM) || !disp_en || !en_mask[idx]
                    || (blink_en && blink_ph);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            led_seg <= 8'hFF;
            dig_sel <= '1;
        end else if (blank) begin
            led_seg <= 8'hFF;
            dig_sel <= '1;
        end else begin
            led_seg <= {~dp_mask[idx], hex_decode(nibble)};
            dig_sel <= sel8[NUM_DIGITS-1:0];
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            2'd0: rdata = data32;
            2'd1: rdata = {14'b0, blink_en, disp_en, dp_mask, en_mask};
            2'd2: rdata = {28'b0, blink_ph, idx};
            default: rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl: directed plan steps plus random register
// traffic, checked against a cycle-count based reference model.
module tb_seg_display_ctrl;

    localparam int N  = 8;
    localparam int SD = 8;
    localparam int GD = 2;
    localparam int BS = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [7:0]  led_seg;
    logic [N-1:0] dig_sel;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int          mt;
    int          bf;
    logic [31:0] mdata;
    logic [7:0]  men;
    logic [7:0]  mdp;
    logic        mdisp;
    logic        mblink;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30,
                                 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03,
                                 7'h46, 7'h21, 7'h06, 7'h0E};

    seg_display_ctrl #(
        .NUM_DIGITS(N), .SCAN_DIV(SD), .GUARD(GD), .BLINK_SCANS(BS)
    ) dut (
        .clk(clk), .rstn(rstn), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .led_seg(led_seg), .dig_sel(dig_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    function automatic int m_idx();
        return (mt / SD) % N;
    endfunction

    function automatic logic m_ph();
        return ((bf / BS) % 2) == 1;
    endfunction

    task automatic model_reset();
        mt = 0; bf = 0; mdata = '0; men = 8'hFF; mdp = '0;
        mdisp = 1'b1; mblink = 1'b0;
    endtask

    // One clock edge with optional write; checks outputs and STATUS after it
    task automatic step(input logic w, input logic [1:0] a,
                        input logic [31:0] d);
        int         i;
        logic [7:0] es;
        logic [7:0] ed;
        logic       bl;
        i  = m_idx();
        bl = ((mt % SD) < GD) || !mdisp || !men[i] || (mblink && m_ph());
        es = bl ? 8'hFF : {~mdp[i], hex_tab[mdata[4*i +: 4]]};
        ed = bl ? 8'hFF : ~(8'(1) << i);
        we = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
        if (!mblink) bf = 0;
        else if ((mt % SD) == SD - 1 && i == N - 1) bf++;
        mt++;
        if (w && a == 2'd0) mdata = d;
        if (w && a == 2'd1) begin
            men = d[7:0]; mdp = d[15:8]; mdisp = d[16]; mblink = d[17];
        end
        we = 1'b0;
        check("led_seg", 32'(led_seg), 32'(es));
        check("dig_sel", 32'(dig_sel), 32'(ed));
        addr = 2'd2;
        #1;
        check("status", rdata, {28'b0, m_ph(), 3'(m_idx())});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 2'd0, 32'd0);
    endtask

    task automatic read_chk(input string tag, input logic [1:0] a,
                            input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    initial begin
        model_reset();
        #12;
        check("reset_seg", 32'(led_seg), 32'hFF);
        check("reset_sel", 32'(dig_sel), 32'hFF);
        read_chk("reset_ctrl", 2'd1, 32'h0001_00FF);
        @(negedge clk);
        rstn = 1'b1;

        // Power-up scan, digits show 0
        idle(70);

        step(1'b1, 2'd0, 32'h89AB_CDEF);
        read_chk("data_rb", 2'd0, 32'h89AB_CDEF);
        idle(70);

        step(1'b1, 2'd1, 32'h0001_01FD);
        idle(70);

        // Blink, then drop blink_en while the display is dark
        step(1'b1, 2'd1, 32'h0003_00FF);
        idle(300);
        begin
            int guard_cnt;
            guard_cnt = 0;
            while (!m_ph() && guard_cnt < 1000) begin
                step(1'b0, 2'd0, 32'd0);
                guard_cnt++;
            end
            check("blink_wait", 32'(m_ph()), 32'd1);
        end
        step(1'b1, 2'd1, 32'h0001_00FF);
        idle(20);

        // Random register traffic
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                logic [31:0] d;
                d = $urandom();
                if ($urandom_range(0, 2) != 0) d[17] = 1'b0;
                if ($urandom_range(0, 3) != 0) d[16] = 1'b1;
                step(1'b1, 2'($urandom_range(0, 3)), d);
            end else begin
                step(1'b0, 2'd0, 32'd0);
            end
        end

        // Asynchronous reset mid-slot
        step(1'b1, 2'd1, 32'h0001_00FF);
        step(1'b1, 2'd0, 32'h1234_5678);
        idle(SD + 3);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_seg", 32'(led_seg), 32'hFF);
        check("arst_sel", 32'(dig_sel), 32'hFF);
        read_chk("arst_data", 2'd0, 32'h0);
        read_chk("arst_stat", 2'd2, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        idle(2 * SD);

        // Read-back and reserved offsets
        step(1'b1, 2'd1, 32'hFFFF_FFFF);
        read_chk("ctrl_rb", 2'd1, 32'h0003_FFFF);
        step(1'b1, 2'd2, 32'hFFFF_FFFF);
        step(1'b1, 2'd3, 32'hFFFF_FFFF);
        read_chk("rsvd_rd", 2'd3, 32'h0);
        read_chk("data_keep", 2'd0, 32'h0);
        idle(40);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
